// File: rtl/led_row_driver.sv
// LED matrix row driver: synchronises the rotating column enable, blanks on
// every column change and drives rows from a double-buffered frame store.
module led_row_driver #(
    parameter int ROWS         = 8,
    parameter int BLANK_CYCLES = 4
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic [3:0]      colEn,
    input  logic            wrEn,
    input  logic [1:0]      wrCol,
    input  logic [ROWS-1:0] wrData,
    input  logic            swapReq,
    output logic            swapPending,
    output logic            swapAck,
    output logic            frameStart,
    output logic [3:0]      colOut,
    output logic [ROWS-1:0] rowOut
);

    localparam logic [7:0] CNT_INIT = 8'(BLANK_CYCLES - 1);

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    logic [3:0]      r_sync1;
    logic [3:0]      r_colSync;
    logic [3:0]      r_colPrev;
    state_t          r_state;
    state_t          w_stateNxt;
    logic [7:0]      r_cnt;
    logic [7:0]      w_cntNxt;
    logic [ROWS-1:0] r_bank [2][4];
    logic            r_sel;

    logic            w_change;
    logic            w_frame;
    logic            w_swap;
    logic            w_oneHot;
    logic [1:0]      w_idx;
    logic            w_drive;
    logic [ROWS-1:0] w_frontRow;

    assign w_change   = (r_colSync != r_colPrev);
    assign w_frame    = w_change && (r_colSync == 4'b0001);
    assign w_swap     = w_frame && swapPending;
    assign w_frontRow = r_bank[r_sel][w_idx];

    always_comb begin
        w_oneHot = 1'b1;
        w_idx    = 2'd0;
        case (r_colSync)
            4'b0001: w_idx = 2'd0;
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_oneHot = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sync1   <= 4'b0000;
            r_colSync <= 4'b0000;
            r_colPrev <= 4'b0000;
        end else begin
            r_sync1   <= colEn;
            r_colSync <= r_sync1;
            if (w_change) begin
                r_colPrev <= r_colSync;
            end
        end
    end

    // A change event always wins over counter expiry, so a glitching
    // column restarts the full blank interval.
    always_comb begin
        w_stateNxt = r_state;
        w_cntNxt   = r_cnt;
        if (w_change) begin
            w_stateNxt = ST_BLANK;
            w_cntNxt   = CNT_INIT;
        end else begin
            unique case (r_state)
                ST_BLANK: begin
                    if (r_cnt == 8'd0) begin
                        w_stateNxt = ST_DRIVE;
                    end else begin
                        w_cntNxt = r_cnt - 8'd1;
                    end
                end
                ST_DRIVE: begin
                    w_stateNxt = ST_DRIVE;
                end
            endcase
        end
        w_drive = (w_stateNxt == ST_DRIVE) && w_oneHot;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_BLANK;
            r_cnt   <= CNT_INIT;
        end else begin
            r_state <= w_stateNxt;
            r_cnt   <= w_cntNxt;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            colOut <= 4'b0000;
            rowOut <= '0;
        end else if (w_drive) begin
            colOut <= r_colSync;
            rowOut <= w_frontRow;
        end else begin
            colOut <= 4'b0000;
            rowOut <= '0;
        end
    end

    // A request arriving on the swap edge re-arms for the next frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            swapPending <= 1'b0;
            swapAck     <= 1'b0;
            frameStart  <= 1'b0;
            r_sel       <= 1'b0;
        end else begin
            frameStart <= w_frame;
            swapAck    <= w_swap;
            if (w_swap) begin
                r_sel       <= ~r_sel;
                swapPending <= swapReq;
            end else begin
                swapPending <= swapPending | swapReq;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < 4; c++) begin
                    r_bank[b][c] <= '0;
                end
            end
        end else if (wrEn) begin
            r_bank[~r_sel][wrCol] <= wrData;
        end
    end

endmodule

// File: doc/led_row_driver.md
# led_row_driver

Downstream consumer of the one-hot column-enable rotator in the LED matrix display path. Takes the rotating 4-bit column enable, which is asynchronous to this block's clock, and synchronises it. Drives the row lines for the active column from a double-buffered 4-column frame store, inserting an anti-ghosting blank interval on every column change. Game logic writes the back bank and requests a swap, which commits only at a frame boundary.

## Interface
- ROWS, 8, row lines per column; frame store is 4 x ROWS bits per bank.
- BLANK_CYCLES, 4, clk cycles of blanking on each column change; legal range 1..255.

- clk  in  1  system clock; all state on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- colEn  in  4  one-hot column enable from column multiplexer; asynchronous to clk.
- wrEn  in  1  write strobe into back bank.
- wrCol  in  2  column index for write (0 = colEn 4'b0001 … 3 = 4'b1000).
- wrData  in  ROWS  row pattern for wrCol.
- swapReq  in  1  one-cycle request to swap banks at next frame boundary.
- swapPending  out  1  swap requested, not yet executed.
- swapAck  out  1  one-cycle pulse on the edge the swap executes.
- frameStart  out  1  one-cycle pulse when a change to column 4'b0001 is detected.
- colOut  out  4  gated column enable to drivers, aligned with rowOut.
- rowOut  out  ROWS  row pattern for colOut's column.

## Operation
- Synchroniser: colEn -> sync1 -> colSync (2 flops). colPrev holds the last accepted colSync.
- Change event: colSync != colPrev. On that edge: colPrev <= colSync, state <= BLANK, blank counter <= BLANK_CYCLES-1.
- States: BLANK, DRIVE.
  - BLANK: colOut = 0, rowOut = 0. A new change event restarts the counter. When counter = 0 and no change event: state <= DRIVE.
  - DRIVE: colOut <= colSync, rowOut <= front[idx(colSync)], registered every cycle.
- Non-one-hot colSync (including 0000): colOut and rowOut are forced to 0 in either state. It still counts as a change event when it differs from colPrev.
- Banks: bank[0], bank[1], select bit sel. front = bank[sel], back = bank[~sel]. Swap toggles sel; no copy is made. After a swap, the back bank holds the previous frame.
- Write: wrEn writes back[wrCol] <= wrData, any cycle, any state.
- Swap: swapReq sets swapPending, which is sticky. A change event with colSync = 4'b0001 asserts frameStart. If swapPending is set on that edge: sel toggles, swapAck pulses, and swapPending clears.
- swapReq while already pending: no additional effect.
- Simultaneous cases:
  - swapReq on the swap edge: the swap executes, and swapPending stays 1 for the next frame.
  - wrEn on the swap edge: the write lands in the pre-swap back bank, i.e. the new front bank.
- Reset (resetN low, asynchronous):
  - Bank state: both banks cleared to 0, sel = 0.
  - Synchroniser and control: sync flops and colPrev = 0000, state = BLANK, counter = BLANK_CYCLES-1.
  - Outputs: colOut = 0, rowOut = 0, swapPending = 0, swapAck = 0, frameStart = 0.
  - Reset asserted mid-frame drops the outputs to 0 immediately; a pending swap is discarded.

## Timing
- colEn changes, then is sampled at edge k. colSync is valid after k+1, and the change event occurs at edge k+2.
- colOut/rowOut are 0 from edge k+2 through k+1+BLANK_CYCLES. The new column is driven from edge k+2+BLANK_CYCLES; with the default, edge k+6.
- Old column keeps driving through edge k+1; there is never overlap between old and new columns.
- swapAck and frameStart assert at edge k+2, lasting one cycle. The new front bank is first visible at edge k+2+BLANK_CYCLES.
- A write is visible on rowOut no earlier than the first DRIVE cycle after the swap that exposes its bank.
- Minimum colEn dwell for any drive time: more than BLANK_CYCLES+2 clk cycles.

## Test plan
- Reset: drive colEn = 0010 until in DRIVE, then pull resetN low asynchronously. colOut = 0 and rowOut = 0 before the next clk edge; swapPending = 0. After release, outputs remain 0 until a valid column completes blanking.
- Swap and display: write back cols 0..3 = 0x11, 0x22, 0x44, 0x88, pulse swapReq, then rotate colEn to 0001. Expect swapAck and frameStart at the change edge, and colOut = 0001 with rowOut = 0x11 after 4 blank cycles. Then 0010 gives 0x22, 1000 gives 0x88.
- Latency: colEn 0001 -> 0010 sampled at edge k. Expect colOut = 0 at edges k+2..k+5, and colOut = 0010 with rowOut = front[1] at k+6.
- Glitch and invalid input: change colEn again at blank cycle 2; the counter restarts and there are 4 full blank cycles after the second change. colEn = 0011: outputs stay 0 indefinitely.
- Simultaneous events: with swapPending = 1, assert wrEn (col 0, 0x5A) and swapReq on the swap edge. Expect sel to toggle, rowOut = 0x5A for column 0001 after blanking, and swapPending = 1 afterwards.
- No request: a wrap to 0001 without swapReq gives a frameStart pulse, no swapAck, and an unchanged front pattern.
